regfile_sb: RTL and testbench

- Parametrised successor to the 16x16 three-read register file used by the single-cycle datapath.
- Configurable width, depth and read-port count.
- Adds a per-register busy scoreboard for multi-cycle and in-flight producers, same-cycle write-to-read bypass, and a live count of busy registers.
- Sits between decode and the ALU and memory stages, and feeds hazard/stall logic.

---
 rtl/regfile_sb.sv | 103 ++++++++++
 tb/tb_regfile_sb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Parameterised register file with a per-register busy scoreboard, an optional
// same-cycle write-to-read bypass and a registered count of busy registers.
// Reads are combinational (0 cycles). Writes and busy updates land on the rising edge.
// No backpressure: every write, busy_set and flush is accepted in the cycle it is presented.
//
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_rd_addr / o_rd_data / o_rd_busy  NUM_RD packed read ports (port i in slice i)
//   i_wr_en, i_wr_addr, i_wr_data    single write port; a write also clears busy
//   i_busy_set, i_busy_addr          mark a register as having an outstanding producer
//   i_flush                          clear every busy bit (pipeline squash)
//   o_busy_cnt                       registered popcount of the busy vector
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 3,
  parameter int ZERO_R0  = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_busy,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_busy_set,
  input  logic [ADDR_W-1:0]          i_busy_addr,
  input  logic                       i_flush,
  output logic [ADDR_W:0]            o_busy_cnt
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W:0]     r_busy_cnt;

  logic                w_wr_eff;
  logic                w_set_eff;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [ADDR_W:0]     w_cnt_nxt;

  // Writes and busy marks aimed at a hardwired R0 are dropped. Gating with
  // reset keeps the bypass path from forwarding data while the file is held clear.
  assign w_wr_eff  = i_wr_en && !i_rst &&
                     !((ZERO_R0 != 0) && (i_wr_addr == '0));
  assign w_set_eff = i_busy_set &&
                     !((ZERO_R0 != 0) && (i_busy_addr == '0));

  // Busy next-state: a new producer beats both flush and a retiring write
  // to the same register; flush beats the write clear (all bits go to 0 anyway).
  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (w_set_eff && (i_busy_addr == ADDR_W'(r))) begin
        w_busy_nxt[r] = 1'b1;
      end else if (i_flush) begin
        w_busy_nxt[r] = 1'b0;
      end else if (w_wr_eff && (i_wr_addr == ADDR_W'(r))) begin
        w_busy_nxt[r] = 1'b0;
      end
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[r]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wr_eff) begin
        r_regs[i_wr_addr] <= i_wr_data;
      end
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign o_busy_cnt = r_busy_cnt;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_zero;
    logic              w_fwd;

    assign w_addr = i_rd_addr[p*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_R0 != 0) && (w_addr == '0);
    // A forwarded write means the producer has just delivered, so the port
    // sees the new value and no longer reports the register as busy.
    assign w_fwd  = (BYPASS != 0) && w_wr_eff && (i_wr_addr == w_addr);

    assign o_rd_data[p*DATA_W +: DATA_W] = w_zero ? '0 :
                                           w_fwd  ? i_wr_data :
                                                    r_regs[w_addr];
    assign o_rd_busy[p] = !w_zero && !w_fwd && r_busy[w_addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [11:0] rd_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy_set;
  logic [3:0]  busy_addr;
  logic        flush;

  logic [47:0] rd_data_b,  rd_data_nb;
  logic [2:0]  rd_busy_b,  rd_busy_nb;
  logic [4:0]  busy_cnt_b, busy_cnt_nb;

  int checks   = 0;
  int failures = 0;

  regfile_sb #(.BYPASS(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
    .o_rd_busy(rd_busy_b), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_busy_set(busy_set), .i_busy_addr(busy_addr),
    .i_flush(flush), .o_busy_cnt(busy_cnt_b)
  );

  regfile_sb #(.BYPASS(0)) u_dut_nb (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_nb),
    .o_rd_busy(rd_busy_nb), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_busy_set(busy_set), .i_busy_addr(busy_addr),
    .i_flush(flush), .o_busy_cnt(busy_cnt_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; busy_set = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [15:0] dat_b(input int p);
    return rd_data_b[p*16 +: 16];
  endfunction

  function automatic logic [15:0] dat_nb(input int p);
    return rd_data_nb[p*16 +: 16];
  endfunction

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    busy_set = 1'b0; busy_addr = '0; flush = 1'b0;

    // Reset state
    #12;
    rd_addr = {4'd3, 4'd8, 4'd5};
    #1;
    chk("rst_cnt", 32'(busy_cnt_b), 32'd0);
    chk("rst_rd0", 32'(dat_b(0)), 32'h0);
    chk("rst_busy", 32'(rd_busy_b), 32'd0);
    rst = 1'b0;
    tick();

    // Write R5, mark R8 busy, then reset asynchronously mid-cycle
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    busy_set = 1'b1; busy_addr = 4'd8;
    tick();
    idle();
    #1;
    chk("pre_rst_r5", 32'(dat_b(0)), 32'hBEEF);
    chk("pre_rst_busy8", 32'(rd_busy_b[1]), 32'd1);
    chk("pre_rst_cnt", 32'(busy_cnt_b), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_r5", 32'(dat_b(0)), 32'h0);
    chk("arst_busy8", 32'(rd_busy_b[1]), 32'd0);
    chk("arst_cnt", 32'(busy_cnt_b), 32'd0);
    rst = 1'b0;
    tick();

    // R3 write, then R0 write with a busy_set on R0 (both discarded for R0)
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    tick();
    wr_addr = 4'd0; wr_data = 16'hFFFF; busy_set = 1'b1; busy_addr = 4'd0;
    tick();
    idle();
    rd_addr = {4'd0, 4'd0, 4'd3};
    #1;
    chk("r3_rd", 32'(dat_b(0)), 32'h1234);
    chk("r0_rd", 32'(dat_b(1)), 32'h0);
    chk("r0_busy", 32'(rd_busy_b[1]), 32'd0);
    chk("r0_cnt", 32'(busy_cnt_b), 32'd0);

    // Bypass: old R7 = 0x1111, then same-cycle write of 0xA5A5 with all ports on R7
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1111;
    tick();
    wr_data = 16'hA5A5;
    rd_addr = {4'd7, 4'd7, 4'd7};
    #1;
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("byp_p%0d", p), 32'(dat_b(p)), 32'hA5A5);
      chk($sformatf("nobyp_old_p%0d", p), 32'(dat_nb(p)), 32'h1111);
    end
    tick();
    idle();
    #1;
    chk("nobyp_new", 32'(dat_nb(2)), 32'hA5A5);

    // Scoreboard set then clear by write
    busy_set = 1'b1; busy_addr = 4'd4;
    tick();
    busy_addr = 4'd9;
    tick();
    idle();
    rd_addr = {4'd9, 4'd0, 4'd4};
    #1;
    chk("sb_busy4", 32'(rd_busy_b[0]), 32'd1);
    chk("sb_busy9", 32'(rd_busy_b[2]), 32'd1);
    chk("sb_cnt2", 32'(busy_cnt_b), 32'd2);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0042;
    #1;
    chk("sb_byp_busy4", 32'(rd_busy_b[0]), 32'd0);
    chk("sb_byp_data4", 32'(dat_b(0)), 32'h0042);
    chk("sb_nobyp_busy4", 32'(rd_busy_nb[0]), 32'd1);
    tick();
    idle();
    #1;
    chk("sb_cnt1", 32'(busy_cnt_b), 32'd1);
    chk("sb_busy4_clr", 32'(rd_busy_nb[0]), 32'd0);

    // Set beats a same-cycle write to the same register
    busy_set = 1'b1; busy_addr = 4'd6;
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h6666;
    tick();
    idle();
    rd_addr = {4'd2, 4'd9, 4'd6};
    #1;
    chk("sim_data6", 32'(dat_b(0)), 32'h6666);
    chk("sim_busy6", 32'(rd_busy_b[0]), 32'd1);
    chk("sim_cnt", 32'(busy_cnt_b), 32'd2);

    // Set beats flush
    flush = 1'b1; busy_set = 1'b1; busy_addr = 4'd2;
    tick();
    idle();
    #1;
    chk("fl_busy_vec", 32'(rd_busy_b), 32'b100);
    chk("fl_cnt", 32'(busy_cnt_b), 32'd1);

    // Saturation: R2 already busy, mark R1..R15
    busy_set = 1'b1;
    for (int r = 1; r < 16; r++) begin
      busy_addr = 4'(r);
      tick();
      if (r == 1) chk("sat_cnt_r1", 32'(busy_cnt_b), 32'd2);
      if (r == 3) chk("sat_cnt_r3", 32'(busy_cnt_b), 32'd3);
    end
    chk("sat_cnt15", 32'(busy_cnt_b), 32'd15);
    chk("sat_cnt15_nb", 32'(busy_cnt_nb), 32'd15);
    busy_addr = 4'd1;
    tick();
    chk("sat_hold15", 32'(busy_cnt_b), 32'd15);
    idle();
    flush = 1'b1;
    tick();
    idle();
    chk("sat_flush", 32'(busy_cnt_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
